// File: rtl/rsa_job_scheduler.sv
// rsa_job_scheduler: two-requester front end for one RSA control datapath.
// It accepts a job, pulses the inverter reset, waits for the inverter to
// finish, then does the same for mod_exp, and returns the result. A watchdog
// aborts either wait state after TIMEOUT_CYCLES cycles.
// Optional feature: define RSA_KEY_REUSE_EN to skip the inverter phase when
// the accepted p/q match the last key that was successfully inverted.
module rsa_job_scheduler #(
  parameter int unsigned WIDTH          = 128,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [WIDTH-1:0]     req0_p,
  input  logic [WIDTH-1:0]     req0_q,
  input  logic                 req0_encrypt_decrypt,
  input  logic [2*WIDTH-1:0]   req0_msg,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [WIDTH-1:0]     req1_p,
  input  logic [WIDTH-1:0]     req1_q,
  input  logic                 req1_encrypt_decrypt,
  input  logic [2*WIDTH-1:0]   req1_msg,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [2*WIDTH-1:0]   rsp_msg,
  output logic                 rsp_err,
  output logic                 busy,
  output logic [WIDTH-1:0]     ctl_p,
  output logic [WIDTH-1:0]     ctl_q,
  output logic                 ctl_encrypt_decrypt,
  output logic [2*WIDTH-1:0]   ctl_msg_in,
  output logic                 ctl_reset_inverter,
  output logic                 ctl_reset_mod_exp,
  input  logic                 ctl_inverter_finish,
  input  logic                 ctl_mod_exp_finish,
  input  logic [2*WIDTH-1:0]   ctl_msg_out
);

  typedef enum logic [2:0] {
    StIdle, StInvPulse, StInvWait, StExpPulse, StExpWait, StResp
  } state_e;

  localparam logic [15:0] WdogLast = 16'(TIMEOUT_CYCLES - 1);

  state_e        state_q, state_d;
  logic [15:0]   wdog_q, wdog_d;
  logic          last_id_q;
  logic          grant, grant_valid, accept;
  logic          inv_done, exp_done, abort;
  logic          key_hit;
  logic [WIDTH-1:0] sel_p, sel_q;

  // Round-robin grant: on a tie the requester not served last wins.
  always_comb begin
    grant_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) grant = ~last_id_q;
    else                          grant = req1_valid;
    accept     = (state_q == StIdle) && grant_valid;
    req0_ready = accept && !grant;
    req1_ready = accept && grant;
    sel_p      = grant ? req1_p : req0_p;
    sel_q      = grant ? req1_q : req0_q;
  end

`ifdef RSA_KEY_REUSE_EN
  logic [WIDTH-1:0] key_p_q, key_q_q;
  logic             key_valid_q;

  // Key cache: set on inverter finish, dropped on any watchdog abort.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_p_q     <= '0;
      key_q_q     <= '0;
      key_valid_q <= 1'b0;
    end else if (abort) begin
      key_valid_q <= 1'b0;
    end else if (inv_done) begin
      key_p_q     <= ctl_p;
      key_q_q     <= ctl_q;
      key_valid_q <= 1'b1;
    end
  end

  // Key hit compares the incoming job against the cached key.
  always_comb key_hit = key_valid_q && (sel_p == key_p_q) && (sel_q == key_q_q);
`else
  // Without key storage every job runs the inverter phase.
  always_comb key_hit = 1'b0;
`endif

  // Next-state, watchdog and strobe generation.
  always_comb begin
    state_d            = state_q;
    wdog_d             = wdog_q;
    ctl_reset_inverter = 1'b0;
    ctl_reset_mod_exp  = 1'b0;
    inv_done           = 1'b0;
    exp_done           = 1'b0;
    abort              = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = key_hit ? StExpPulse : StInvPulse;
      end
      StInvPulse: begin
        ctl_reset_inverter = 1'b1;
        wdog_d             = '0;
        state_d            = StInvWait;
      end
      StInvWait: begin
        // Finish takes priority over a coincident watchdog expiry.
        if (ctl_inverter_finish) begin
          inv_done = 1'b1;
          state_d  = StExpPulse;
        end else if (wdog_q == WdogLast) begin
          abort   = 1'b1;
          state_d = StResp;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
      end
      StExpPulse: begin
        ctl_reset_mod_exp = 1'b1;
        wdog_d            = '0;
        state_d           = StExpWait;
      end
      StExpWait: begin
        if (ctl_mod_exp_finish) begin
          exp_done = 1'b1;
          state_d  = StResp;
        end else if (wdog_q == WdogLast) begin
          abort   = 1'b1;
          state_d = StResp;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Status outputs decoded straight from the state register.
  always_comb begin
    rsp_valid = (state_q == StResp);
    busy      = (state_q != StIdle);
  end

  // State, watchdog, job latch and response capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q             <= StIdle;
      wdog_q              <= '0;
      last_id_q           <= 1'b1;
      ctl_p               <= '0;
      ctl_q               <= '0;
      ctl_encrypt_decrypt <= 1'b0;
      ctl_msg_in          <= '0;
      rsp_id              <= 1'b0;
      rsp_msg             <= '0;
      rsp_err             <= 1'b0;
    end else begin
      state_q <= state_d;
      wdog_q  <= wdog_d;
      if (accept) begin
        ctl_p               <= sel_p;
        ctl_q               <= sel_q;
        ctl_encrypt_decrypt <= grant ? req1_encrypt_decrypt : req0_encrypt_decrypt;
        ctl_msg_in          <= grant ? req1_msg : req0_msg;
        rsp_id              <= grant;
        last_id_q           <= grant;
      end
      if (exp_done) begin
        rsp_msg <= ctl_msg_out;
        rsp_err <= 1'b0;
      end else if (abort) begin
        rsp_msg <= '0;
        rsp_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rsa_job_scheduler.sv
// Scoreboard bench for rsa_job_scheduler with a behavioural datapath stub.
// Honours RSA_KEY_REUSE_EN in its reference model when defined.
module tb_rsa_job_scheduler;
  localparam int unsigned W  = 128;
  localparam int unsigned TO = 16;

  typedef struct {
    bit             id;
    bit             err;
    logic [2*W-1:0] msg;
    int             lat;
    int             n_inv;
    int             n_exp;
  } exp_t;

  logic clk, reset_n;
  logic req0_ready, req1_ready, rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [2*W-1:0] rsp_msg, ctl_msg_in, dp_out;
  logic [W-1:0] ctl_p, ctl_q;
  logic ctl_encrypt_decrypt, ctl_reset_inverter, ctl_reset_mod_exp;
  logic inv_fin, exp_fin;

  // Per-requester job fields and attributes that steer the stub.
  logic [W-1:0]   jp[2], jq[2];
  logic [2*W-1:0] jm[2];
  logic           jd[2], jv[2];
  int             jli[2], jle[2];
  bit             jhi[2], jhe[2];

  int n_cmp = 0, n_fail = 0, cyc = 0, rr_mode = 2;
  int cur_li, cur_le, inv_cnt, exp_cnt;
  bit cur_hi, cur_he, inv_act, exp_act;

  exp_t sbq[$];
  bit last_m = 1, kv_m = 0, prev_v = 0, hs_prev = 0;
  logic [W-1:0] kp_m, kq_m;
  int acc_cyc, n_inv_obs, n_exp_obs;
  logic [2*W-1:0] held_msg;
  bit held_id, held_err;

  rsa_job_scheduler #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(jv[0]), .req0_ready(req0_ready), .req0_p(jp[0]), .req0_q(jq[0]),
    .req0_encrypt_decrypt(jd[0]), .req0_msg(jm[0]),
    .req1_valid(jv[1]), .req1_ready(req1_ready), .req1_p(jp[1]), .req1_q(jq[1]),
    .req1_encrypt_decrypt(jd[1]), .req1_msg(jm[1]),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_msg(rsp_msg),
    .rsp_err(rsp_err), .busy(busy), .ctl_p(ctl_p), .ctl_q(ctl_q),
    .ctl_encrypt_decrypt(ctl_encrypt_decrypt), .ctl_msg_in(ctl_msg_in),
    .ctl_reset_inverter(ctl_reset_inverter), .ctl_reset_mod_exp(ctl_reset_mod_exp),
    .ctl_inverter_finish(inv_fin), .ctl_mod_exp_finish(exp_fin), .ctl_msg_out(dp_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in cipher: direction 0 rotates left after xor with {p,q}; 1 undoes it.
  function automatic logic [2*W-1:0] dp_func(input logic [W-1:0] p, input logic [W-1:0] q,
                                             input logic d, input logic [2*W-1:0] m);
    logic [2*W-1:0] x;
    if (!d) begin
      x = m ^ {p, q};
      return {x[2*W-2:0], x[2*W-1]};
    end
    return {m[0], m[2*W-1:1]} ^ {p, q};
  endfunction

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, wanted %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // Datapath stub: finish rises a set number of cycles after its reset strobe.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inv_fin <= 0; exp_fin <= 0; inv_act <= 0; exp_act <= 0;
      inv_cnt <= 0; exp_cnt <= 0; dp_out <= '0;
    end else begin
      if (ctl_reset_inverter) begin
        inv_fin <= 0; inv_cnt <= cur_li; inv_act <= !cur_hi;
      end else if (inv_act) begin
        if (inv_cnt == 0) begin inv_fin <= 1; inv_act <= 0; end
        else inv_cnt <= inv_cnt - 1;
      end
      if (ctl_reset_mod_exp) begin
        exp_fin <= 0; exp_cnt <= cur_le; exp_act <= !cur_he;
      end else if (exp_act) begin
        if (exp_cnt == 0) begin
          exp_fin <= 1; exp_act <= 0;
          dp_out  <= dp_func(ctl_p, ctl_q, ctl_encrypt_decrypt, ctl_msg_in);
        end else exp_cnt <= exp_cnt - 1;
      end
    end
  end

  // Monitor: predicts at acceptance, compares when a response appears.
  always @(negedge clk) begin
    if (!reset_n) begin
      sbq.delete(); last_m = 1; kv_m = 0; prev_v = 0; hs_prev = 0;
    end else begin
      if (ctl_reset_inverter) n_inv_obs++;
      if (ctl_reset_mod_exp) n_exp_obs++;
      if (jv[0] && jv[1]) check("ready_exclusive", 256'(req0_ready & req1_ready), 0);
      if (hs_prev) begin check("idle_after_rsp", 256'(busy), 0); hs_prev = 0; end
      if ((jv[0] && req0_ready) || (jv[1] && req1_ready)) begin
        exp_t e;
        bit id, want, hit, hi_eff;
        id   = jv[1] && req1_ready;
        want = (jv[0] && jv[1]) ? !last_m : jv[1];
        check("grant", 256'(id), 256'(want));
        last_m = id;
`ifdef RSA_KEY_REUSE_EN
        hit = kv_m && jp[id] == kp_m && jq[id] == kq_m;
`else
        hit = 0;
`endif
        hi_eff  = hit ? 0 : jhi[id];
        e.id    = id;
        e.err   = hi_eff || jhe[id];
        e.msg   = e.err ? '0 : dp_func(jp[id], jq[id], jd[id], jm[id]);
        e.n_inv = hit ? 0 : 1;
        e.n_exp = hi_eff ? 0 : 1;
        // Each phase: pulse, stub delay + 1, then finish sample; hang = 1 + TO.
        e.lat = hit ? 0 : (jhi[id] ? 1 + TO : 3 + jli[id]);
        if (!hi_eff) e.lat += jhe[id] ? 1 + TO : 3 + jle[id];
        if (hit) begin
          if (jhe[id]) kv_m = 0;
        end else if (jhi[id] || jhe[id]) kv_m = 0;
        else begin kv_m = 1; kp_m = jp[id]; kq_m = jq[id]; end
        sbq.push_back(e);
        cur_li = jli[id]; cur_le = jle[id]; cur_hi = jhi[id]; cur_he = jhe[id];
        acc_cyc = cyc + 1; n_inv_obs = 0; n_exp_obs = 0;
      end
      if (rsp_valid) begin
        check("busy_in_rsp", 256'(busy), 1);
        check("ready_in_rsp", 256'(req0_ready | req1_ready), 0);
        if (!prev_v) begin
          if (sbq.size() == 0) bound_fail("unexpected_rsp");
          else begin
            exp_t e;
            e = sbq.pop_front();
            check("rsp_id", 256'(rsp_id), 256'(e.id));
            check("rsp_err", 256'(rsp_err), 256'(e.err));
            check("rsp_msg", rsp_msg, e.msg);
            check("latency", 256'(cyc - acc_cyc), 256'(e.lat));
            check("inv_strobes", 256'(n_inv_obs), 256'(e.n_inv));
            check("exp_strobes", 256'(n_exp_obs), 256'(e.n_exp));
          end
          held_msg = rsp_msg; held_id = rsp_id; held_err = rsp_err;
        end else begin
          check("stable_msg", rsp_msg, held_msg);
          check("stable_id_err", 256'({rsp_id, rsp_err}), 256'({held_id, held_err}));
        end
        if (rsp_ready) hs_prev = 1;
        prev_v = !rsp_ready;
      end else prev_v = 0;
    end
  end

  // Response backpressure: 0 random, 1 held low, 2 held high.
  initial begin
    rsp_ready = 0;
    forever begin
      @(posedge clk); #1;
      rsp_ready = (rr_mode == 2) || (rr_mode == 0 && ($urandom % 4 != 0));
    end
  end

  task automatic submit(input int id, input logic [W-1:0] p, input logic [W-1:0] q,
                        input logic d, input logic [2*W-1:0] m,
                        input int li, input int le, input bit hi, input bit he);
    int n = 0;
    @(posedge clk); #1;
    jp[id] = p; jq[id] = q; jd[id] = d; jm[id] = m;
    jli[id] = li; jle[id] = le; jhi[id] = hi; jhe[id] = he; jv[id] = 1;
    do begin
      @(negedge clk); n++;
    end while (!((id == 0) ? req0_ready : req1_ready) && n < 5000);
    if (n >= 5000) bound_fail("accept_wait");
    @(posedge clk); #1;
    jv[id] = 0;
  endtask

  task automatic req_loop(input int id, input int njobs);
    logic [W-1:0] p, q;
    for (int k = 0; k < njobs; k++) begin
      if ($urandom % 3 == 0) begin p = 128'd1234567; q = 128'd7654321; end
      else begin
        p = {$urandom, $urandom, $urandom, $urandom};
        q = {$urandom, $urandom, $urandom, $urandom};
      end
      submit(id, p, q, 1'($urandom), {4{$urandom, $urandom}},
             ($urandom % 8 == 0) ? 14 : int'($urandom % 7),
             ($urandom % 8 == 0) ? 14 : int'($urandom % 7),
             ($urandom % 10 == 0), ($urandom % 10 == 0));
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end
    while (!(sbq.size() == 0 && !busy && !jv[0] && !jv[1]) && n < 20000);
    if (n >= 20000) bound_fail("idle_wait");
  endtask

  initial begin
    logic [W-1:0] kp, kq;
    int n;
    kp = 128'd113680897410347;
    kq = 128'd7999808077935876437321;
    for (int i = 0; i < 2; i++) begin
      jv[i] = 0; jp[i] = '0; jq[i] = '0; jm[i] = '0; jd[i] = 0;
      jli[i] = 0; jle[i] = 0; jhi[i] = 0; jhe[i] = 0;
    end
    reset_n = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", 256'(rsp_valid), 0);
    check("rst_busy", 256'(busy), 0);
    check("rst_strobes", 256'({ctl_reset_inverter, ctl_reset_mod_exp}), 0);
    check("rst_ctl_pq", {ctl_p, ctl_q}, 0);
    check("rst_ctl_msg", ctl_msg_in, 0);
    check("rst_rsp", {rsp_msg[2*W-3:0], rsp_id, rsp_err}, 0);
    reset_n = 1;

    // Directed job and round trip through the inverse direction.
    submit(0, kp, kq, 0, 256'h57e70000, 3, 5, 0, 0);
    wait_idle();
    submit(0, kp, kq, 1, held_msg, 2, 4, 0, 0);
    wait_idle();
    check("roundtrip", held_msg, 256'h57e70000);

    // Inverter hang: abort lands TO cycles after wait entry; next job normal.
    submit(1, kp, 128'd99, 0, 256'h1234, 0, 0, 1, 0);
    wait_idle();
    submit(1, kp, 128'd99, 0, 256'h1234, 1, 1, 0, 0);
    wait_idle();

    // Contending random traffic with random backpressure.
    rr_mode = 0;
    fork
      req_loop(0, 15);
      req_loop(1, 15);
    join
    wait_idle();

    // Held response with a pending job from the other requester.
    rr_mode = 1;
    submit(0, kp, kq, 0, 256'hbeef, 2, 2, 0, 0);
    fork
      submit(1, kq, kp, 1, 256'hcafe, 1, 1, 0, 0);
    join_none
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 500);
    if (n >= 500) bound_fail("rsp_wait");
    repeat (20) begin
      @(negedge clk);
      check("held_rsp_valid", 256'(rsp_valid), 1);
    end
    rr_mode = 2;
    wait_idle();

    // Reset during EXP_WAIT: everything drops at once and no response follows.
    submit(0, 128'd5, 128'd7, 0, 256'h77, 2, 12, 0, 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!ctl_reset_mod_exp && n < 500);
    if (n >= 500) bound_fail("exp_strobe_wait");
    repeat (2) @(negedge clk);
    @(posedge clk); #3;
    reset_n = 0;
    #1;
    check("arst_busy", 256'(busy), 0);
    check("arst_rsp_valid", 256'(rsp_valid), 0);
    check("arst_ctl", {ctl_p, ctl_q}, 0);
    check("arst_msg", ctl_msg_in | rsp_msg, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    repeat (30) begin
      @(negedge clk);
      check("no_rsp_after_rst", 256'(rsp_valid | busy), 0);
    end
    submit(1, kp, kq, 0, 256'h42, 3, 3, 0, 0);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rsa_job_scheduler.md
# rsa_job_scheduler

Sequences and shares one RSA `control` datapath (inverter phase, then modular-exponent phase) between two job requesters. It accepts a job (key primes p/q, direction, message) over a valid/ready handshake, performs the reset-pulse / wait-for-finish sequencing of both datapath phases, and returns the result over a valid/ready response port. It sits directly above the `control` instance; requesters never drive the datapath's reset strobes themselves.

## Interface
- WIDTH, 128, prime width; messages are 2*WIDTH
- TIMEOUT_CYCLES, 65535, max cycles in either wait state before abort (16-bit counter; legal 1..65535)

- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  job offered by requester 0 / 1
- req0_ready / req1_ready  out  1  job accepted this cycle when valid&ready
- req0_p, req0_q / req1_p, req1_q  in  WIDTH  primes
- req0_encrypt_decrypt / req1_encrypt_decrypt  in  1  direction, passed to datapath
- req0_msg / req1_msg  in  2*WIDTH  message
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_id  out  1  requester that issued the job
- rsp_msg  out  2*WIDTH  datapath msg_out; 0 on error
- rsp_err  out  1  job aborted by watchdog
- busy  out  1  state != IDLE
- ctl_p, ctl_q  out  WIDTH  to datapath
- ctl_encrypt_decrypt  out  1; ctl_msg_in  out  2*WIDTH
- ctl_reset_inverter, ctl_reset_mod_exp  out  1  one-cycle start strobes
- ctl_inverter_finish, ctl_mod_exp_finish  in  1  datapath done flags
- ctl_msg_out  in  2*WIDTH  datapath result

## Operation
- States: IDLE, INV_PULSE, INV_WAIT, EXP_PULSE, EXP_WAIT, RESP.
- IDLE: round-robin grant among valid requesters; pointer `last_id` resets to 1 so requester 0 wins first tie. reqN_ready = (state==IDLE) & grant==N; never both high.
- Accept edge: register p, q, direction, msg into ctl_* outputs, record rsp_id, set last_id=grant, go INV_PULSE. ctl_* held stable until next acceptance.
- INV_PULSE: ctl_reset_inverter=1 for exactly one cycle -> INV_WAIT.
- INV_WAIT: on ctl_inverter_finish=1 -> EXP_PULSE. Datapath clears finish during its reset strobe, so stale finish is not possible.
- EXP_PULSE: ctl_reset_mod_exp=1 one cycle -> EXP_WAIT.
- EXP_WAIT: on ctl_mod_exp_finish=1 capture ctl_msg_out into rsp_msg, rsp_err=0 -> RESP.
- Watchdog: counter cleared on entry to each wait state, increments per cycle; reaching TIMEOUT_CYCLES without finish -> RESP with rsp_msg=0, rsp_err=1.
- RESP: rsp_valid=1, rsp_* stable; on rsp_ready=1 -> IDLE (new job acceptable the following cycle, not same cycle).
- Finish arriving in same cycle as watchdog expiry: finish wins.

## Timing
- Reset values: all outputs 0, state IDLE, watchdog 0, last_id=1. reset_n low mid-job aborts immediately; no response generated, strobes drop asynchronously.
- Accept at edge T: INV_PULSE during cycle T+1, INV_WAIT from T+2. Finish sampled at edge E: EXP_PULSE in cycle E+1, EXP_WAIT from E+2. mod_exp finish sampled at edge F: rsp_valid high from F+1.
- Fixed overhead excluding datapath latency: 4 cycles (without key reuse).
- rsp_valid stays high until handshake; a requester's valid may drop without acceptance (no ordering obligation).

## Configuration
- RSA_KEY_REUSE_EN defined: scheduler keeps last successfully inverted p/q plus key_valid flag; if accepted job's p and q equal stored key and key_valid=1, skip INV_PULSE/INV_WAIT and go straight to EXP_PULSE. key_valid cleared on reset and on any watchdog abort; set on inverter finish.
- Undefined: every job runs both phases; no key storage.

## Test plan
- Single job req0: p=113680897410347, q=7999808077935876437321, encrypt_decrypt=0, msg=0x57e70000 -> one inverter strobe, one mod_exp strobe, rsp_valid with rsp_id=0, rsp_err=0; resubmitting rsp_msg with encrypt_decrypt=1 returns 0x57e70000.
- req0 and req1 valid same cycle, both held -> served 0,1,0,1; ready never high for both.
- rsp_ready held low 20 cycles after result -> rsp_valid/rsp_msg stable, req*_ready stays 0, busy=1.
- Stub datapath never raises inverter finish, TIMEOUT_CYCLES=16 -> rsp_err=1, rsp_msg=0 exactly 16 cycles after INV_WAIT entry; next job proceeds normally.
- reset_n pulsed low during EXP_WAIT -> all outputs 0 at once, state IDLE, no rsp_valid.
- With RSA_KEY_REUSE_EN: two jobs same p/q -> second has no ctl_reset_inverter strobe and 2 fewer overhead cycles; changed q -> inverter runs again.
